seq_multiplier: RTL and testbench

- Parametrised, iterative shift-add multiplier; the multi-cycle successor to the team's fixed 8-bit combinational array multiplier.
- Computes a WIDTH x WIDTH product, unsigned or two's-complement signed, selected per operation.
- Uses a valid/ready handshake on the input and output sides.
- Sits beside the datapath ALU, which needs small-area multiplies where WIDTH-cycle latency is acceptable.

---
 rtl/mult_pkg.sv | 25 ++
 rtl/seq_multiplier_cond_negate.sv | 28 ++
 rtl/seq_multiplier.sv | 180 ++++++++++++++++++
 tb/tb_seq_multiplier.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-add multiplier:
//   - state_t      : controller states (IDLE, CALC, FIX, DONE)
//   - MODE_*       : operand interpretation selected through is_signed
//   - cnt_width()  : width of an iteration counter that must hold WIDTH
// ---------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // The counter has to reach the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_cond_negate.sv
// ---------------------------------------------------------------------------
// cond_negate
// Conditional two's-complement negation: y = neg ? (~x + 1) : x.
// Ports:
//   x   [N-1:0]  value to convert
//   neg          1 = negate, 0 = pass through
//   y   [N-1:0]  result (the most negative value maps onto itself, which
//                reads correctly as its unsigned magnitude)
// ---------------------------------------------------------------------------
module cond_negate #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic         neg,
  output logic [N-1:0] y
);

  // Select between the pass-through and the negated value
  always_comb begin
    y = x;
    if (neg) begin
      y = ~x + N'(1);
    end else begin
      y = x;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add WIDTH x WIDTH multiplier, unsigned or two's-complement
// per operation. Operands are converted to magnitudes on acceptance, the
// magnitudes are multiplied with one add/shift step per clock, and the sign
// is applied to the 2*WIDTH-bit result in a single fix-up cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   a, b and is_signed are valid
//   in_ready   ready to accept an operation (IDLE only)
//   a, b       multiplicand / multiplier, WIDTH bits
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   out_valid  o holds a product (DONE only)
//   out_ready  consumer takes the product
//   o          product, 2*WIDTH bits, stable while out_valid is high and
//              kept after the handshake until the next result is written
//   busy       high in every state except IDLE
//
// Timing: acceptance at edge k, out_valid rises at edge k+WIDTH+2. The CALC
// state performs WIDTH add/shift iterations and uses one further cycle to
// observe the finished count before handing over to FIX.
// ---------------------------------------------------------------------------
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   o,
  output logic                 busy
);

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  // {carry, high half, low half}; the carry catches the add overflow so the
  // right shift brings it back into the top of the product.
  logic [2*WIDTH:0]     acc;
  logic                 neg;

  logic                 signed_mode;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       partial;
  logic [2*WIDTH:0]     acc_next;
  logic [2*WIDTH-1:0]   fixed;

  // Operand sign decode for the magnitude conversion
  always_comb begin
    signed_mode = 1'b0;
    a_neg       = 1'b0;
    b_neg       = 1'b0;
    if (is_signed == MODE_SIGNED) begin
      signed_mode = 1'b1;
      a_neg       = a[WIDTH-1];
      b_neg       = b[WIDTH-1];
    end else begin
      signed_mode = 1'b0;
      a_neg       = 1'b0;
      b_neg       = 1'b0;
    end
  end

  cond_negate #(.N(WIDTH)) u_mag_a (
    .x   (a),
    .neg (a_neg),
    .y   (mag_a)
  );

  cond_negate #(.N(WIDTH)) u_mag_b (
    .x   (b),
    .neg (b_neg),
    .y   (mag_b)
  );

  cond_negate #(.N(2*WIDTH)) u_fix (
    .x   (acc[2*WIDTH-1:0]),
    .neg (neg),
    .y   (fixed)
  );

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift {carry, accumulator} right.
  always_comb begin
    addend   = '0;
    partial  = '0;
    acc_next = '0;
    if (mplier[0]) begin
      addend = {1'b0, mcand};
    end else begin
      addend = '0;
    end
    partial  = {acc[2*WIDTH], acc[2*WIDTH-1:WIDTH]} + addend;
    acc_next = {1'b0, partial, acc[WIDTH-1:1]};
  end

  // Controller and datapath registers, including all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      o         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= mag_a;
            mplier   <= mag_b;
            neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc      <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end else begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end

        CALC: begin
          if (count == CNT_W'(WIDTH)) begin
            state <= FIX;
          end else begin
            acc    <= acc_next;
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            count  <= count + CNT_W'(1);
          end
        end

        FIX: begin
          o         <= fixed;
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Self-checking bench for seq_multiplier at WIDTH=8. Expected products come
// from plain integer multiplication of the operands interpreted as signed or
// unsigned; the soak test keeps a queue of expected products in order.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  localparam int W        = 8;
  localparam int LATENCY  = W + 2;
  localparam int SOAK_OPS = 1500;
  localparam int SOAK_MAX = 40000;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] o;
  logic           busy;

  int n_checks;
  int n_fail;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: the operands read as integers in the requested mode.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic s);
    longint p;
    if (s) p = longint'($signed(x)) * longint'($signed(y));
    else   p = longint'(x) * longint'(y);
    return p[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; is_signed = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (o !== 16'h0000)     begin n_fail++; $display("FAIL reset_o: got %h expected 0000", o); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  // One operation with out_ready held high: product, latency, pulse width,
  // return to IDLE and o retained after the handshake.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic s, input string name);
    logic [2*W-1:0] exp;
    int lat;
    exp = model(xa, xb, s);
    out_ready = 1'b1;
    a = xa; b = xb; is_signed = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_accept: in_ready got %b expected 0", name, in_ready); end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    n_checks++; if (lat !== LATENCY) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LATENCY); end
    n_checks++; if (o !== exp)       begin n_fail++; $display("FAIL %s_product: got %h expected %h", name, o, exp); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL %s_release: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready); end
    n_checks++; if (o !== exp)       begin n_fail++; $display("FAIL %s_hold: got %h expected %h", name, o, exp); end
  endtask

  task automatic test_directed();
    do_op(8'hFF, 8'hFF, 1'b0, "unsigned_max");
    do_op(8'h80, 8'h80, 1'b1, "signed_min_sq");
    do_op(8'hFF, 8'h01, 1'b1, "signed_m1");
    do_op(8'hFF, 8'h01, 1'b0, "unsigned_ff");
    do_op(8'h00, 8'hA5, 1'b0, "zero");
    do_op(8'h01, 8'h7F, 1'b1, "identity");
    do_op(8'h80, 8'h7F, 1'b1, "signed_mixed");
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] exp;
    int wait_cyc;
    exp = model(8'h13, 8'hF2, 1'b1);
    out_ready = 1'b0;
    a = 8'h13; b = 8'hF2; is_signed = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_cyc = 0;
    while (out_valid !== 1'b1 && wait_cyc < 40) begin
      tick();
      wait_cyc++;
    end
    n_checks++; if (o !== exp) begin n_fail++; $display("FAIL bp_product: got %h expected %h", o, exp); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); is_signed = 1'b0;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || o !== exp || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: out_valid=%b o=%h in_ready=%b expected 1/%h/0", i, out_valid, o, in_ready, exp);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    tick();
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_ignored_inputs: busy=%b out_valid=%b expected 0/0", busy, out_valid); end
  endtask

  task automatic test_reset_mid_op();
    int stray;
    out_ready = 1'b1;
    a = 8'hC3; b = 8'h5A; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();     // now inside the 4th CALC cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || o !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_reset: in_ready=%b busy=%b out_valid=%b o=%h expected 1/0/0/0000", in_ready, busy, out_valid, o);
    end
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid === 1'b1) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL mid_reset_stray: got %0d out_valid cycles expected 0", stray); end
    do_op(8'h03, 8'h05, 1'b0, "after_reset");
  endtask

  task automatic test_random_soak();
    logic [2*W-1:0] q[$];
    logic [2*W-1:0] exp;
    int sent, recv, cyc, bad;
    sent = 0; recv = 0; cyc = 0; bad = 0;
    while ((sent < SOAK_OPS || recv < SOAK_OPS) && cyc < SOAK_MAX) begin
      a         = W'($urandom);
      b         = W'($urandom);
      is_signed = 1'($urandom_range(0, 1));
      in_valid  = (sent < SOAK_OPS) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      // Handshakes that the coming edge will sample.
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, is_signed));
        sent++;
      end
      if (out_valid && out_ready) begin
        recv++;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL soak_duplicate: product %h with nothing outstanding", o);
        end else begin
          exp = q.pop_front();
          if (o !== exp) begin
            n_fail++;
            bad++;
            if (bad < 10) $display("FAIL soak_product #%0d: got %h expected %h", recv, o, exp);
          end
        end
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (sent !== SOAK_OPS || recv !== SOAK_OPS || q.size() !== 0) begin
      n_fail++;
      $display("FAIL soak_count: sent=%0d received=%0d outstanding=%0d expected %0d/%0d/0",
               sent, recv, q.size(), SOAK_OPS, SOAK_OPS);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
